pwr_load_array: RTL and testbench

- Parametrised array of NUM_MODULES synthetic switching loads for FPGA dynamic-power characterisation.
- Each channel has an LFSR that drives a PIPE_DEPTH-stage register pipeline, and produces one registered dummy output so synthesis cannot prune the load.
- Requested enables pass through a ramp controller that turns channels on one at a time, limiting current steps. A global duty setting throttles toggle density.

---
 rtl/pwr_load_pkg.sv | 28 ++
 rtl/pwr_load_cell.sv | 50 +++++
 rtl/pwr_load_array.sv | 115 +++++++++++
 tb/tb_pwr_load_array.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pwr_load_pkg.sv
// Shared constants, types and helpers for the synthetic switching-load array.
package pwr_load_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned DUTY_W = 4;

  // Feedback taps: bits 0, 2, 3 and 5 of the current state.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  typedef enum logic {
    IDLE,
    RAMP
  } ramp_state_e;

  // Isolates the lowest set bit; callers zero-extend and truncate to their width.
  function automatic logic [255:0] lowest_set(input logic [255:0] v);
    return v & (~v + 256'd1);
  endfunction

  // Channel seed: index+1 truncated to the LFSR width, never all-zero.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input int unsigned idx);
    logic [LFSR_W-1:0] s;
    s = LFSR_W'(idx + 1);
    if (s == '0) s = {{(LFSR_W-1){1'b0}}, 1'b1};
    return s;
  endfunction

endpackage

// File: rtl/pwr_load_cell.sv
// One load channel: LFSR feeding a mixing pipeline, XOR-reduced into a dummy output.
module pwr_load_cell
  import pwr_load_pkg::*;
#(
  parameter int unsigned IDX        = 0,
  parameter int unsigned PIPE_DEPTH = 4
) (
  input  logic clk100m,
  input  logic rstn,
  input  logic adv,
  output logic dummy_out
);

  logic [LFSR_W-1:0]                  lfsr_q, lfsr_d;
  logic [PIPE_DEPTH-1:0][LFSR_W-1:0] stage_q, stage_d;
  logic                               dout_q, dout_d;
  logic                               fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  // Advance LFSR and pipeline together only when enabled; otherwise hold (no toggling).
  always_comb begin
    lfsr_d  = lfsr_q;
    stage_d = stage_q;
    if (adv) begin
      lfsr_d     = {fb, lfsr_q[LFSR_W-1:1]};
      stage_d[0] = lfsr_q;
      for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
        stage_d[k] = stage_q[k-1] ^ {stage_q[k-1][LFSR_W-2:0], stage_q[k-1][LFSR_W-1]};
      end
    end
    dout_d = ^stage_q[PIPE_DEPTH-1];
  end

  // Channel state registers.
  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      lfsr_q  <= lfsr_seed(IDX);
      stage_q <= '0;
      dout_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      stage_q <= stage_d;
      dout_q  <= dout_d;
    end
  end

  assign dummy_out = dout_q;

endmodule

// File: rtl/pwr_load_array.sv
// Array of switching loads with a one-at-a-time turn-on ramp and global duty throttle.
module pwr_load_array
  import pwr_load_pkg::*;
#(
  parameter int unsigned NUM_MODULES = 32,
  parameter int unsigned PIPE_DEPTH  = 4,
  parameter int unsigned RAMP_CYCLES = 16
) (
  input  logic                             clk100m,
  input  logic                             rstn,
  input  logic [NUM_MODULES-1:0]           pwr_en_in,
  input  logic [DUTY_W-1:0]                duty_sel,
  output logic [NUM_MODULES-1:0]           dummy_out,
  output logic [NUM_MODULES-1:0]           eff_en_out,
  output logic [$clog2(NUM_MODULES+1)-1:0] active_count,
  output logic                             ramp_busy
);

  localparam int unsigned CNT_W  = $clog2(NUM_MODULES + 1);
  localparam int unsigned RCNT_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RAMP_CYCLES - 1);

  logic [NUM_MODULES-1:0] req_q, eff_q, eff_d;
  logic [NUM_MODULES-1:0] pend, low_bit, set_bit, adv;
  logic [DUTY_W-1:0]      ph_q, ph_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  ramp_state_e            state_q, state_d;
  logic                   act;

  assign pend    = req_q & ~eff_q;
  assign low_bit = NUM_MODULES'(lowest_set(256'(pend)));
  assign act     = (ph_q <= duty_sel);
  assign ph_d    = ph_q + 1'b1;

  // Ramp FSM next state: one channel turns on per RAMP_CYCLES, lowest index first.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    set_bit = '0;
    unique case (state_q)
      IDLE: begin
        if (pend != '0) begin
          state_d = RAMP;
          rcnt_d  = RCNT_LOAD;
        end
      end
      RAMP: begin
        if (pend == '0) begin
          state_d = IDLE;
        end else if (rcnt_q == '0) begin
          set_bit = low_bit;
          if ((pend & ~low_bit) != '0) begin
            rcnt_d = RCNT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ramp_busy = (state_q == RAMP);
  end

  // Withdrawn requests drop immediately; new ones only enter via the ramp.
  always_comb begin
    eff_d = (eff_q & req_q) | set_bit;
    cnt_d = '0;
    for (int i = 0; i < int'(NUM_MODULES); i++) begin
      cnt_d = cnt_d + CNT_W'(eff_q[i]);
    end
  end

  // Control state registers.
  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      req_q   <= '0;
      eff_q   <= '0;
      ph_q    <= '0;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      req_q   <= pwr_en_in;
      eff_q   <= eff_d;
      ph_q    <= ph_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign adv          = eff_q & {NUM_MODULES{act}};
  assign eff_en_out   = eff_q;
  assign active_count = cnt_q;

  for (genvar g = 0; g < int'(NUM_MODULES); g++) begin : g_cell
    pwr_load_cell #(
      .IDX       (g),
      .PIPE_DEPTH(PIPE_DEPTH)
    ) u_cell (
      .clk100m  (clk100m),
      .rstn     (rstn),
      .adv      (adv[g]),
      .dummy_out(dummy_out[g])
    );
  end

endmodule

// File: tb/tb_pwr_load_array.sv
// Directed bench for pwr_load_array with default parameters.
module tb_pwr_load_array;

  logic        clk100m = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pwr_en_in = '0;
  logic [3:0]  duty_sel = '0;
  logic [31:0] dummy_out, eff_en_out;
  logic [5:0]  active_count;
  logic        ramp_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk100m = ~clk100m;

  pwr_load_array dut (
    .clk100m     (clk100m),
    .rstn        (rstn),
    .pwr_en_in   (pwr_en_in),
    .duty_sel    (duty_sel),
    .dummy_out   (dummy_out),
    .eff_en_out  (eff_en_out),
    .active_count(active_count),
    .ramp_busy   (ramp_busy)
  );

  wire [15:0] lfsr0 = dut.g_cell[0].u_cell.lfsr_q;
  wire [15:0] lfsr5 = dut.g_cell[5].u_cell.lfsr_q;

  // Reference model of channel 0 (LFSR, 4-stage pipeline, dummy bit, phase counter).
  logic [15:0] m_l;
  logic [15:0] m_st[4];
  logic        m_d;
  logic [3:0]  m_ph;
  logic        m_adv = 1'b0;

  always @(negedge clk100m) m_adv = eff_en_out[0] && (m_ph <= duty_sel);

  always @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      m_l  <= 16'h0001;
      for (int k = 0; k < 4; k++) m_st[k] <= '0;
      m_d  <= 1'b0;
      m_ph <= '0;
    end else begin
      m_ph <= m_ph + 4'd1;
      m_d  <= ^m_st[3];
      if (m_adv) begin
        m_l     <= {m_l[0] ^ m_l[2] ^ m_l[3] ^ m_l[5], m_l[15:1]};
        m_st[0] <= m_l;
        for (int k = 1; k < 4; k++) m_st[k] <= m_st[k-1] ^ {m_st[k-1][14:0], m_st[k-1][15]};
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk100m);
    #1;
  endtask

  function automatic logic [31:0] mask(input int k);
    logic [63:0] one;
    one = 64'd1;
    return 32'((one << k) - 64'd1);
  endfunction

  int          changes;
  logic [15:0] prev;

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      pwr_en_in = $urandom;
      duty_sel  = 4'($urandom);
      step(1);
    end
    chk("rst_eff", eff_en_out, 0);
    chk("rst_dummy", dummy_out, 0);
    chk("rst_count", active_count, 0);
    chk("rst_busy", ramp_busy, 0);

    // Release with no requests.
    pwr_en_in = '0;
    duty_sel  = 4'd15;
    rstn      = 1'b1;
    step(20);
    chk("idle_eff", eff_en_out, 0);
    chk("idle_dummy", dummy_out, 0);
    chk("idle_busy", ramp_busy, 0);
    chk("idle_lfsr0", lfsr0, 16'h0001);
    chk("idle_lfsr5", lfsr5, 16'h0006);

    // Single channel: first edge after drive is E; bit rises at E+17.
    pwr_en_in = 32'h1;
    step(17);
    chk("one_pre_eff", eff_en_out, 0);
    chk("one_pre_busy", ramp_busy, 1);
    step(1);
    chk("one_eff", eff_en_out, 32'h1);
    chk("one_busy", ramp_busy, 0);
    chk("one_cnt_lag", active_count, 0);
    chk("one_lfsr_hold", lfsr0, 16'h0001);
    step(1);
    chk("one_cnt", active_count, 1);
    chk("one_lfsr_adv", lfsr0, 16'h8000);
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("run_dummy0", dummy_out[0], m_d);
      chk("run_lfsr0", lfsr0, m_l);
    end
    chk("run_dummy_off", dummy_out[31:1], 0);

    // Duty throttling: advances over 32 consecutive edges.
    duty_sel = 4'd0;
    changes = 0;
    prev = lfsr0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (lfsr0 != prev) changes++;
      prev = lfsr0;
    end
    chk("duty0_adv", changes, 2);
    duty_sel = 4'd7;
    changes = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (lfsr0 != prev) changes++;
      prev = lfsr0;
    end
    chk("duty7_adv", changes, 16);
    chk("duty_dummy0", dummy_out[0], m_d);
    chk("duty_lfsr0", lfsr0, m_l);
    duty_sel = 4'd15;

    // Disable is immediate and the LFSR then holds.
    pwr_en_in = '0;
    step(1);
    chk("off_eff_e", eff_en_out, 32'h1);
    step(1);
    chk("off_eff", eff_en_out, 0);
    chk("off_busy", ramp_busy, 0);
    prev = lfsr0;
    step(10);
    chk("off_cnt", active_count, 0);
    chk("off_lfsr_hold", lfsr0, prev);
    chk("off_lfsr_model", lfsr0, m_l);

    // All channels ramp at 16-cycle spacing.
    pwr_en_in = '1;
    step(17);
    for (int k = 0; k < 32; k++) begin
      chk("all_pre", eff_en_out, mask(k));
      chk("all_busy", ramp_busy, 1);
      step(1);
      chk("all_post", eff_en_out, mask(k + 1));
      if (k < 31) step(15);
    end
    chk("all_busy_end", ramp_busy, 0);
    step(1);
    chk("all_cnt", active_count, 32);

    // Withdrawal mid-ramp after channel 3 is on.
    pwr_en_in = '0;
    step(2);
    chk("wd_clear", eff_en_out, 0);
    pwr_en_in = '1;
    step(66);
    chk("wd_four_on", eff_en_out, 32'hF);
    pwr_en_in = '0;
    step(1);
    chk("wd_eff_e", eff_en_out, 32'hF);
    step(1);
    chk("wd_eff", eff_en_out, 0);
    chk("wd_busy", ramp_busy, 0);
    step(40);
    chk("wd_eff_hold", eff_en_out, 0);
    chk("wd_busy_hold", ramp_busy, 0);
    chk("wd_cnt", active_count, 0);

    // Reset mid-ramp with five channels on.
    pwr_en_in = '1;
    step(82);
    chk("mr_five_on", eff_en_out, 32'h1F);
    step(3);
    chk("mr_cnt", active_count, 5);
    chk("mr_busy", ramp_busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mr_eff", eff_en_out, 0);
    chk("mr_cnt0", active_count, 0);
    chk("mr_busy0", ramp_busy, 0);
    chk("mr_dummy", dummy_out, 0);
    chk("mr_lfsr0", lfsr0, 16'h0001);
    @(posedge clk100m);
    #1;
    rstn = 1'b1;
    step(17);
    chk("mr_pre_eff", eff_en_out, 0);
    chk("mr_pre_busy", ramp_busy, 1);
    step(1);
    chk("mr_restart", eff_en_out, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
